// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite memory test master: writes a selectable pattern over a block of words, reads it
// back and checks it, counting mismatches/HRESP errors and completed passes.
module ahb_lite_mem_tester #(
  parameter int          ADDR_WIDTH     = 32,
  parameter int          WORD_CNT       = 16000,
  parameter int          ADDR_INCREMENT = 4,
  parameter int          ERR_WIDTH      = 32,
  parameter int          PASS_WIDTH     = 8,
  parameter logic [31:0] LFSR_SEED      = 32'hACE12468
) (
  input  logic                  HCLK_i,
  input  logic                  HRESET_i,
  input  logic                  START_i,
  input  logic [1:0]            MODE_i,
  input  logic                  LOOP_i,
  input  logic [ADDR_WIDTH-1:0] STARTADDR_i,
  output logic [ADDR_WIDTH-1:0] HADDR_o,
  output logic [2:0]            HBURST_o,
  output logic                  HSEL_o,
  output logic [2:0]            HSIZE_o,
  output logic [1:0]            HTRANS_o,
  output logic [31:0]           HWDATA_o,
  output logic                  HWRITE_o,
  input  logic [31:0]           HRDATA_i,
  input  logic                  HREADY_i,
  input  logic                  HRESP_i,
  output logic [ERR_WIDTH-1:0]  ERRCOUNT_o,
  output logic [PASS_WIDTH-1:0] PASSCOUNT_o,
  output logic [ADDR_WIDTH-1:0] FIRST_ERR_ADDR_o,
  output logic                  BUSY_o,
  output logic                  S_WRITE_o,
  output logic                  S_CHECK_o,
  output logic                  S_SUCCESS_o,
  output logic                  S_FAILED_o
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WRITE  = 3'd1;
  localparam logic [2:0] ST_WDRAIN = 3'd2;
  localparam logic [2:0] ST_READ   = 3'd3;
  localparam logic [2:0] ST_RDRAIN = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam int                    IDX_W     = (WORD_CNT > 1) ? $clog2(WORD_CNT) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(WORD_CNT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(ADDR_INCREMENT);
  localparam logic [31:0]           LFSR_TAPS = 32'h80200003;

  logic [2:0]            state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic                  loop_q, loop_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [31:0]           dp_data_q, dp_data_d;
  logic [ADDR_WIDTH-1:0] dp_addr_q, dp_addr_d;
  logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;
  logic [PASS_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
  logic [ADDR_WIDTH-1:0] first_err_q, first_err_d;
  logic                  err_seen_q, err_seen_d;

  logic [31:0] addr32;
  logic [4:0]  bit_sel;
  logic [31:0] pattern;
  logic [31:0] lfsr_step;
  logic        addr_phase;
  logic        err_event;

  assign addr32    = 32'(addr_q);
  assign bit_sel   = 5'(idx_q);
  assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

  always_comb begin
    pattern = addr32;
    case (mode_q)
      2'd0:    pattern = addr32;
      2'd1:    pattern = ~addr32;
      2'd2:    pattern = lfsr_q;
      default: pattern = 32'd1 << bit_sel;
    endcase
  end

  assign addr_phase = (state_q == ST_WRITE) || (state_q == ST_READ);
  // One error per transfer: only the completing (HREADY=1) data-phase cycle is judged.
  assign err_event  = dp_valid_q && HREADY_i &&
                      (HRESP_i || (!dp_write_q && (HRDATA_i != dp_data_q)));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    loop_d       = loop_q;
    start_addr_d = start_addr_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    lfsr_d       = lfsr_q;
    dp_valid_d   = dp_valid_q;
    dp_write_d   = dp_write_q;
    dp_data_d    = dp_data_q;
    dp_addr_d    = dp_addr_q;
    err_cnt_d    = err_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    first_err_d  = first_err_q;
    err_seen_d   = err_seen_q;

    if (HREADY_i) begin
      dp_valid_d = 1'b0;
    end

    if (err_event) begin
      if (!(&err_cnt_q)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if (!err_seen_q) begin
        first_err_d = dp_addr_q;
        err_seen_d  = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START_i) begin
          mode_d       = MODE_i;
          loop_d       = LOOP_i;
          start_addr_d = STARTADDR_i;
          addr_d       = STARTADDR_i;
          idx_d        = '0;
          lfsr_d       = LFSR_SEED;
          err_cnt_d    = '0;
          pass_cnt_d   = '0;
          first_err_d  = '0;
          err_seen_d   = 1'b0;
          state_d      = ST_WRITE;
        end else if ((state_q == ST_DONE) && loop_q) begin
          addr_d  = start_addr_q;
          idx_d   = '0;
          lfsr_d  = LFSR_SEED;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE, ST_READ: begin
        if (HREADY_i) begin
          dp_valid_d = 1'b1;
          dp_write_d = (state_q == ST_WRITE);
          dp_data_d  = pattern;
          dp_addr_d  = addr_q;
          idx_d      = idx_q + 1'b1;
          addr_d     = addr_q + ADDR_STEP;
          lfsr_d     = lfsr_step;
          if (idx_q == LAST_IDX) begin
            state_d = (state_q == ST_WRITE) ? ST_WDRAIN : ST_RDRAIN;
          end
        end
      end
      ST_WDRAIN: begin
        // Read pass restarts the address and LFSR so expected data matches what was written.
        if (HREADY_i) begin
          addr_d  = start_addr_q;
          idx_d   = '0;
          lfsr_d  = LFSR_SEED;
          state_d = ST_READ;
        end
      end
      ST_RDRAIN: begin
        if (HREADY_i) begin
          pass_cnt_d = pass_cnt_q + 1'b1;
          state_d    = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK_i or posedge HRESET_i) begin
    if (HRESET_i) begin
      state_q      <= ST_IDLE;
      mode_q       <= '0;
      loop_q       <= 1'b0;
      start_addr_q <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      lfsr_q       <= LFSR_SEED;
      dp_valid_q   <= 1'b0;
      dp_write_q   <= 1'b0;
      dp_data_q    <= '0;
      dp_addr_q    <= '0;
      err_cnt_q    <= '0;
      pass_cnt_q   <= '0;
      first_err_q  <= '0;
      err_seen_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      loop_q       <= loop_d;
      start_addr_q <= start_addr_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      lfsr_q       <= lfsr_d;
      dp_valid_q   <= dp_valid_d;
      dp_write_q   <= dp_write_d;
      dp_data_q    <= dp_data_d;
      dp_addr_q    <= dp_addr_d;
      err_cnt_q    <= err_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
      first_err_q  <= first_err_d;
      err_seen_q   <= err_seen_d;
    end
  end

  assign HADDR_o          = addr_phase ? addr_q : '0;
  assign HBURST_o         = 3'b000;
  assign HSEL_o           = (state_q != ST_IDLE);
  assign HSIZE_o          = 3'b010;
  assign HTRANS_o         = addr_phase ? 2'b10 : 2'b00;
  assign HWDATA_o         = (dp_valid_q && dp_write_q) ? dp_data_q : 32'h0;
  assign HWRITE_o         = (state_q == ST_WRITE);
  assign ERRCOUNT_o       = err_cnt_q;
  assign PASSCOUNT_o      = pass_cnt_q;
  assign FIRST_ERR_ADDR_o = first_err_q;
  assign BUSY_o           = (state_q == ST_WRITE) || (state_q == ST_WDRAIN) ||
                            (state_q == ST_READ)  || (state_q == ST_RDRAIN);
  assign S_WRITE_o        = (state_q == ST_WRITE) || (state_q == ST_WDRAIN);
  assign S_CHECK_o        = (state_q == ST_READ)  || (state_q == ST_RDRAIN);
  assign S_SUCCESS_o      = (state_q == ST_DONE) && (err_cnt_q == '0);
  assign S_FAILED_o       = (state_q == ST_DONE) && (err_cnt_q != '0);

endmodule
